// File: rtl/cnn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cnn_ctrl_pkg
// Shared definitions for the CNN pixel feed scheduler: FSM state encoding,
// default image geometry, memory address width and the "all lanes valid"
// output-word pattern.
// ---------------------------------------------------------------------------
package cnn_ctrl_pkg;

    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;
    localparam int DEF_PRIME_ROWS = 4;
    localparam int DEF_OUT_WORDS  = 196;

    // Byte address into the image memory (28*28 = 784 < 1024).
    localparam int ADDR_W = 10;

    // An output word is counted only when every lane reports valid.
    localparam logic [15:0] VALID_ALL = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_WAIT_INTR,
        ST_ROW,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

endpackage

// File: rtl/cnn_pix_addr_gen.sv
// ---------------------------------------------------------------------------
// cnn_pix_addr_gen
// Row/column pixel counters and byte-address generator for the image memory.
// Logical row r maps to memory row IMG_H-1-r when FLIP_ROWS is set, which
// turns BMP bottom-up storage into top-down delivery.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart at logical row 0, column 0 (new image)
//   row_start   : re-align the column counter to 0 before a row burst
//   step        : one pixel read this cycle; advance column (and row on wrap)
//   row         : current logical row (reaches IMG_H after the last row)
//   row_last    : current column is the last pixel of the row
//   addr        : memory byte address of the current pixel
// ---------------------------------------------------------------------------
module cnn_pix_addr_gen
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W     = DEF_IMG_W,
    parameter int IMG_H     = DEF_IMG_H,
    parameter int FLIP_ROWS = 1,
    parameter int ROW_W     = $clog2(IMG_H + 1),
    parameter int COL_W     = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              row_start,
    input  logic              step,
    output logic [ROW_W-1:0]  row,
    output logic              row_last,
    output logic [ADDR_W-1:0] addr
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] mem_row;

    assign row_last = (col == COL_W'(IMG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (row_last) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else if (row_start) begin
            col <= '0;
        end
    end

    // Past the final row the flipped row wraps; the address is never used
    // then because no read is issued outside PRIME/ROW.
    always_comb begin
        mem_row = (FLIP_ROWS != 0) ? (ROW_W'(IMG_H - 1) - row) : row;
        addr    = ADDR_W'(32'(mem_row) * IMG_W + 32'(col));
    end

endmodule

// File: rtl/cnn_feed_scheduler.sv
// ---------------------------------------------------------------------------
// cnn_feed_scheduler
// Feeds a 28x28 8-bit image from byte memory into the cnn datapath. The first
// PRIME_ROWS rows are streamed back-to-back to fill the line buffer; each
// further row is released by a rising edge of the cnn interrupt. Edges that
// arrive while a burst is running are remembered in a one-deep pending flag.
// Fully valid cnn output words are counted; completion is flagged once
// OUT_WORDS words have been seen after the last row.
//
// Ports:
//   axi_clk, axi_rst_n : clock, asynchronous active-low reset
//   i_start            : one-cycle start request, accepted only in IDLE
//   o_mem_rd, o_mem_addr, i_mem_data : image memory read port (1-cycle data)
//   o_pix_valid, o_pix_data          : pixel stream to cnn
//   i_cnn_intr         : cnn interrupt level, rising edge = ready for a row
//   i_cnn_valid        : cnn per-lane output valid
//   o_busy             : image in progress
//   o_done             : image finished (held until the next start)
//   o_out_cnt          : fully valid output words counted
//   o_err              : sticky error (lost interrupt or surplus word)
// ---------------------------------------------------------------------------
module cnn_feed_scheduler
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int PRIME_ROWS = DEF_PRIME_ROWS,
    parameter int OUT_WORDS  = DEF_OUT_WORDS,
    parameter int FLIP_ROWS  = 1
) (
    input  logic        axi_clk,
    input  logic        axi_rst_n,
    input  logic        i_start,
    output logic        o_mem_rd,
    output logic [9:0]  o_mem_addr,
    input  logic [7:0]  i_mem_data,
    output logic        o_pix_valid,
    output logic [7:0]  o_pix_data,
    input  logic        i_cnn_intr,
    input  logic [15:0] i_cnn_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_out_cnt,
    output logic        o_err
);

    localparam int ROW_W = $clog2(IMG_H + 1);

    feed_state_t       state;
    feed_state_t       state_nxt;

    logic [ROW_W-1:0]  row;
    logic              row_last;
    logic [ADDR_W-1:0] gen_addr;

    logic              rd;
    logic              busy;
    logic              row_start;
    logic              accept;

    logic              intr_q;
    logic              intr_edge;
    logic              pending;
    logic              edge_in_burst;

    logic              word_hit;
    logic              cnt_at_max;
    logic              cnt_full_nxt;

    logic              vld_p1;

    assign accept        = (state == ST_IDLE) && i_start;
    assign intr_edge     = i_cnn_intr & ~intr_q;
    assign edge_in_burst = intr_edge && ((state == ST_PRIME) || (state == ST_ROW));

    assign word_hit      = (state != ST_IDLE) && (i_cnn_valid == VALID_ALL);
    assign cnt_at_max    = (o_out_cnt == 8'(OUT_WORDS));
    // Looking one word ahead lets o_done rise the cycle after the final word.
    assign cnt_full_nxt  = cnt_at_max || (word_hit && (o_out_cnt == 8'(OUT_WORDS - 1)));

    cnn_pix_addr_gen #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .FLIP_ROWS (FLIP_ROWS),
        .ROW_W     (ROW_W)
    ) u_addr_gen (
        .clk       (axi_clk),
        .rst_n     (axi_rst_n),
        .clear     (accept),
        .row_start (row_start),
        .step      (rd),
        .row       (row),
        .row_last  (row_last),
        .addr      (gen_addr)
    );

    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every PRIME/ROW cycle is a read, so row_last marks the final read.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = ST_PRIME;
            end
            ST_PRIME: begin
                if (row_last && (row == ROW_W'(PRIME_ROWS - 1))) state_nxt = ST_WAIT_INTR;
            end
            ST_WAIT_INTR: begin
                if (intr_edge || pending) state_nxt = ST_ROW;
            end
            ST_ROW: begin
                if (row_last) begin
                    state_nxt = (row == ROW_W'(IMG_H - 1)) ? ST_DRAIN : ST_WAIT_INTR;
                end
            end
            ST_DRAIN: begin
                if (cnt_full_nxt) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd        = 1'b0;
        busy      = 1'b0;
        row_start = 1'b0;
        unique case (state)
            ST_PRIME, ST_ROW: begin
                rd   = 1'b1;
                busy = 1'b1;
            end
            ST_WAIT_INTR: begin
                busy      = 1'b1;
                row_start = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign o_mem_rd   = rd;
    assign o_mem_addr = rd ? gen_addr : '0;
    assign o_busy     = busy;

    // Interrupt edge detect, pending row request, output word counter, status.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            intr_q    <= 1'b0;
            pending   <= 1'b0;
            o_out_cnt <= '0;
            o_err     <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            intr_q <= i_cnn_intr;
            if (accept) begin
                pending   <= 1'b0;
                o_out_cnt <= '0;
                o_err     <= 1'b0;
                o_done    <= 1'b0;
            end else begin
                // WAIT_INTR always leaves for ROW when pending is set, so the
                // flag is consumed there unconditionally.
                if (state == ST_WAIT_INTR) begin
                    pending <= 1'b0;
                end else if (edge_in_burst) begin
                    if (pending) o_err <= 1'b1;
                    else         pending <= 1'b1;
                end
                if (word_hit) begin
                    if (cnt_at_max) o_err <= 1'b1;
                    else            o_out_cnt <= o_out_cnt + 1'b1;
                end
                if (state_nxt == ST_DONE) o_done <= 1'b1;
            end
        end
    end

    // ---- stage p1: read strobe registered to align with memory data ----
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd;
        end
    end

    assign o_pix_valid = vld_p1;
    assign o_pix_data  = vld_p1 ? i_mem_data : '0;

endmodule

// File: tb/tb_cnn_feed_scheduler.sv
module tb_cnn_feed_scheduler;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int PR = 4;
    localparam int NW = 196;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        intr = 1'b0;
    logic [15:0] cvalid;
    logic [7:0]  mem_data = 8'h00;

    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        busy;
    logic        done;
    logic [7:0]  out_cnt;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int pix_total = 0;
    int pix_base = 0;

    int words_sent = 0;
    int words_target = 0;
    int word_rate = 4;
    int watch_word = 0;

    logic [7:0] mem [0:W*H-1];
    int got_q[$];
    int got_cyc[$];

    cnn_feed_scheduler dut (
        .axi_clk     (clk),
        .axi_rst_n   (rst_n),
        .i_start     (start),
        .o_mem_rd    (mem_rd),
        .o_mem_addr  (mem_addr),
        .i_mem_data  (mem_data),
        .o_pix_valid (pix_valid),
        .o_pix_data  (pix_data),
        .i_cnn_intr  (intr),
        .i_cnn_valid (cvalid),
        .o_busy      (busy),
        .o_done      (done),
        .o_out_cnt   (out_cnt),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte memory: data for a read appears in the following cycle.
    always @(posedge clk) mem_data <= (mem_rd === 1'b1) ? mem[mem_addr] : 8'($urandom);

    always @(negedge clk) begin
        if (pix_valid === 1'b1) begin
            got_q.push_back(int'(pix_data));
            got_cyc.push_back(cyc);
            pix_total <= pix_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] noise();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'hFFFF || $urandom_range(0, 3) == 0) v = 16'h7FFF;
        return v;
    endfunction

    // Output-word driver: sends all-ones words up to words_target, noise otherwise.
    initial begin
        cvalid = 16'h0000;
        forever begin
            @(negedge clk);
            if (words_sent < words_target && $urandom_range(1, word_rate) == 1) begin
                if (words_sent + 1 == watch_word) chk("done_before_last_word", done, 0);
                cvalid = 16'hFFFF;
                words_sent++;
                if (words_sent == watch_word) begin
                    @(negedge clk);
                    cvalid = noise();
                    chk("done_after_last_word", done, 1);
                    chk("busy_after_last_word", busy, 0);
                end
            end else begin
                cvalid = noise();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        got_q.delete();
        got_cyc.delete();
        pix_base = pix_total;
        @(negedge clk);
        start = 1'b0;
        chk("busy_cycle1", busy, 1);
        chk("rd_cycle1", mem_rd, 1);
        chk("done_cleared", done, 0);
        chk("cnt_cleared", out_cnt, 0);
        chk("err_cleared", err, 0);
    endtask

    task automatic pulse_intr(output int t);
        @(negedge clk);
        intr = 1'b1;
        t = cyc;
        @(negedge clk);
        intr = 1'b0;
    endtask

    // Pops n rows of pixels and compares them with the flipped memory rows.
    task automatic expect_rows(input int r0, input int n, input int first_cyc, input string tag);
        int need;
        int waited;
        int px;
        int cc;
        int c0;
        int cl;
        need = n * W;
        waited = 0;
        c0 = 0;
        cl = 0;
        while (got_q.size() < need && waited < need + 100) begin
            @(negedge clk);
            waited++;
        end
        if (got_q.size() < need) begin
            chk({tag, "_count"}, got_q.size(), need);
            got_q.delete();
            got_cyc.delete();
            return;
        end
        for (int i = 0; i < need; i++) begin
            px = got_q.pop_front();
            cc = got_cyc.pop_front();
            if (i == 0) c0 = cc;
            cl = cc;
            chk(tag, px, mem[(H - 1 - (r0 + i / W)) * W + (i % W)]);
        end
        if (first_cyc >= 0) chk({tag, "_first_cycle"}, c0, first_cyc);
        chk({tag, "_contiguous"}, cl - c0, need - 1);
    endtask

    task automatic wait_words(input int target);
        int k;
        k = 0;
        while (words_sent < target && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("words_delivered", words_sent, target);
        @(negedge clk);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", done, 1);
        @(negedge clk);
    endtask

    task automatic release_rows(input int r_first, input int r_last);
        int t;
        for (int r = r_first; r <= r_last; r++) begin
            pulse_intr(t);
            expect_rows(r, 1, t + 2, "row");
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
    endtask

    initial begin
        int t0;
        int t;
        int t2;
        int wbase;

        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Image 1: prime, single row, ignored start, full image with counting
        do_start(t0);
        expect_rows(0, PR, t0 + 2, "prime");
        chk("busy_after_prime", busy, 1);
        repeat (20) @(negedge clk);
        chk("no_pix_before_intr", got_q.size(), 0);
        pulse_intr(t);
        expect_rows(PR, 1, t + 2, "row4");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_pix_without_intr", got_q.size(), 0);
        chk("busy_start_ignored", busy, 1);
        wbase = words_sent;
        word_rate = 4;
        words_target = wbase + NW - 1;
        release_rows(PR + 1, H - 1);
        wait_words(wbase + NW - 1);
        chk("drain_busy", busy, 1);
        chk("drain_not_done", done, 0);
        chk("drain_cnt", out_cnt, NW - 1);
        watch_word = wbase + NW;
        words_target = wbase + NW;
        wait_done();
        chk("img1_cnt", out_cnt, NW);
        chk("img1_done", done, 1);
        chk("img1_busy", busy, 0);
        chk("img1_err", err, 0);
        chk("img1_pixels", pix_total - pix_base, W * H);

        // Image 2: interrupts during the prime burst
        do_start(t0);
        repeat (18) @(negedge clk);
        pulse_intr(t);
        chk("err_single_pending", err, 0);
        repeat (15) @(negedge clk);
        pulse_intr(t);
        chk("err_double_pending", err, 1);
        expect_rows(0, PR, t0 + 2, "prime2");
        expect_rows(PR, 1, t0 + PR * W + 3, "pending_row");
        repeat (40) @(negedge clk);
        chk("one_extra_row", got_q.size(), 0);
        wbase = words_sent;
        word_rate = 2;
        words_target = wbase + NW;
        release_rows(PR + 1, H - 1);
        wait_done();
        chk("img2_cnt", out_cnt, NW);
        chk("img2_err_sticky", err, 1);

        // Image 3: edge on the last read of a row, surplus output word
        do_start(t0);
        wbase = words_sent;
        word_rate = 1;
        words_target = wbase + NW + 1;
        expect_rows(0, PR, t0 + 2, "prime3");
        pulse_intr(t);
        repeat (W - 2) @(negedge clk);
        pulse_intr(t2);
        expect_rows(PR, 1, t + 2, "row4_img3");
        expect_rows(PR + 1, 1, t + W + 3, "edge_on_last_read");
        wait_words(wbase + NW + 1);
        chk("surplus_cnt_saturates", out_cnt, NW);
        chk("surplus_err", err, 1);
        release_rows(PR + 2, H - 1);
        wait_done();
        chk("img3_cnt", out_cnt, NW);
        chk("img3_pixels", pix_total - pix_base, W * H);

        // Image 4: reset in the middle of a row, then restart
        do_start(t0);
        expect_rows(0, PR, t0 + 2, "prime4");
        pulse_intr(t);
        repeat (10) @(negedge clk);
        chk("mid_row_reading", mem_rd, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_pix_valid", pix_valid, 0);
        chk("abort_pix_data", pix_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cnt", out_cnt, 0);
        chk("abort_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        got_cyc.delete();
        repeat (5) @(negedge clk);
        chk("no_pix_after_abort", got_q.size(), 0);
        chk("idle_after_abort", busy, 0);
        do_start(t0);
        expect_rows(0, PR, t0 + 2, "restart_prime");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
